// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle CPU sequencer: instruction fields,
// ALU op codes, state encodings, datapath mux encodings and the control bundle.
package multicycle_control_pkg;

  // Instruction opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes driven to the 32-bit ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Sequencer state encodings; codes 12..15 are unused and recover to FETCH
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC_R  = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDI_EX = 4'd9;
  localparam logic [3:0] S_ADDI_WB = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC next-value select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full set of datapath controls produced each cycle
  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // Every control inactive; each state starts from this and sets only what it needs
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type function field to ALU op translation. valid is low for any funct
// the ALU does not implement, which the sequencer reports as an illegal op.
module alu_op_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  // Pure lookup; unknown functs fall back to ADD with valid low
  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer of the multicycle CPU. One instruction at a time it steps
// through fetch, decode and the class-specific execute/memory/writeback
// states, driving ALU op, mux selects and write enables for the datapath.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  FETCH   | read instr at PC, PC+4 into PC; waits on mem_ready
//  DECODE  | branch target into ALUOut; dispatch on opcode/funct
//  MEMADR  | base + signext imm -> ALUOut (lw/sw address)
//  MEMRD   | read data memory at ALUOut; waits on mem_ready
//  MEMWB   | MDR -> rt
//  MEMWR   | write regB to memory at ALUOut; waits on mem_ready
//  EXEC_R  | regA op regB, op from funct
//  ALUWB   | ALUOut -> rd
//  BRANCH  | regA - regB; load PC from ALUOut when zero
//  ADDI_EX | regA + signext imm
//  ADDI_WB | ALUOut -> rt
//  JUMP    | load PC with jump target
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W       = 4,
  parameter int ALUOP_W       = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               ready;
  logic [2:0]         fn_alu_op;
  logic               fn_valid;
  logic [STATE_W-1:0] decode_target;
  logic               decode_legal;
  ctrl_t              ctl;
  ctrl_t              ctl_out;

  // Without a handshake the memory is assumed to complete every access in one cycle
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  alu_op_decode u_alu_op_decode (
    .funct  (funct),
    .alu_op (fn_alu_op),
    .valid  (fn_valid)
  );

  // Dispatch target out of DECODE; anything unsupported returns to FETCH
  always_comb begin
    decode_target = S_FETCH;
    decode_legal  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        decode_target = S_EXEC_R;
        decode_legal  = fn_valid;
      end
      OP_LW:   decode_target = S_MEMADR;
      OP_SW:   decode_target = S_MEMADR;
      OP_BEQ:  decode_target = S_BRANCH;
      OP_ADDI: decode_target = S_ADDI_EX;
      OP_J:    decode_target = S_JUMP;
      default: decode_legal  = 1'b0;
    endcase
    if (!decode_legal) begin
      decode_target = S_FETCH;
    end
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; memory states hold until the access completes
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:   state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_nxt = decode_target;
      S_MEMADR:  state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nxt = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_nxt = S_FETCH;
      S_MEMWR:   state_nxt = ready ? S_FETCH : S_MEMWR;
      S_EXEC_R:  state_nxt = S_ALUWB;
      S_ALUWB:   state_nxt = S_FETCH;
      S_BRANCH:  state_nxt = S_FETCH;
      S_ADDI_EX: state_nxt = S_ADDI_WB;
      S_ADDI_WB: state_nxt = S_FETCH;
      S_JUMP:    state_nxt = S_FETCH;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Per-state datapath controls; only FETCH and BRANCH look at live inputs
  always_comb begin
    ctl = ctrl_idle();
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_src    = PCSRC_ALU;
        ctl.ir_write  = ready;
        ctl.pc_en     = ready;
      end
      S_DECODE: begin
        ctl.alu_src_b  = SRCB_IMM_SH2;
        ctl.alu_op     = ALU_ADD;
        ctl.illegal_op = ~decode_legal;
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REGB;
        ctl.alu_op    = fn_alu_op;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REGB;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PCSRC_ALUOUT;
        ctl.pc_en     = zero;
      end
      S_ADDI_EX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_src = PCSRC_JUMP;
        ctl.pc_en  = 1'b1;
      end
      default: ctl = ctrl_idle();
    endcase
  end

  // Reset suppresses every write and request in the same cycle, so an
  // aborted instruction can never commit a partial update
  always_comb begin
    ctl_out = ctl;
    if (rst) begin
      ctl_out.pc_en      = 1'b0;
      ctl_out.mem_read   = 1'b0;
      ctl_out.mem_write  = 1'b0;
      ctl_out.ir_write   = 1'b0;
      ctl_out.reg_write  = 1'b0;
      ctl_out.illegal_op = 1'b0;
      ctl_out.alu_op     = ALU_ADD;
    end
  end

  assign pc_en      = ctl_out.pc_en;
  assign i_or_d     = ctl_out.i_or_d;
  assign mem_read   = ctl_out.mem_read;
  assign mem_write  = ctl_out.mem_write;
  assign ir_write   = ctl_out.ir_write;
  assign mem_to_reg = ctl_out.mem_to_reg;
  assign reg_dst    = ctl_out.reg_dst;
  assign reg_write  = ctl_out.reg_write;
  assign alu_src_a  = ctl_out.alu_src_a;
  assign alu_src_b  = ctl_out.alu_src_b;
  assign pc_src     = ctl_out.pc_src;
  assign alu_op     = ctl_out.alu_op;
  assign illegal_op = ctl_out.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded by
// an instruction-level model into the expected per-cycle control vectors,
// which a single compare process checks against the DUT on the falling edge.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic       rst;
    logic       mem_ready;
    logic       zero;
    logic [5:0] opcode;
    logic [5:0] funct;
    ctl_t       exp;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;

  ctl_t  dut_ctl;
  ctl_t  cur_exp;
  logic  chk_en = 1'b0;
  string tag = "";
  int    checks = 0;
  int    failures = 0;
  step_t q[$];
  ctl_t  trace[$];

  logic [5:0] m_op;
  logic [5:0] m_fn;
  logic       m_z;
  logic       idle_rdy = 1'b1;

  multicycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  assign dut_ctl = {pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op};

  // Single compare point: every played cycle is checked and recorded
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      trace.push_back(dut_ctl);
      if (dut_ctl !== cur_exp) begin
        failures++;
        $display("FAIL %s cyc%0d: got %h expected %h", tag, trace.size(), dut_ctl, cur_exp);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  function automatic int r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
    c.ir_write = rdy; c.pc_en = rdy;
    return c;
  endfunction

  function automatic ctl_t c_decode(input logic ill);
    ctl_t c = '0;
    c.alu_src_b = 2'b11; c.alu_op = 3'b010; c.illegal_op = ill;
    return c;
  endfunction

  function automatic ctl_t c_imm_add();
    ctl_t c = '0;
    c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b010;
    return c;
  endfunction

  function automatic ctl_t c_mem(input logic wr);
    ctl_t c = '0;
    c.i_or_d = 1; c.mem_read = ~wr; c.mem_write = wr;
    return c;
  endfunction

  function automatic ctl_t c_wb(input logic from_mem, input logic to_rd);
    ctl_t c = '0;
    c.reg_write = 1; c.mem_to_reg = from_mem; c.reg_dst = to_rd;
    return c;
  endfunction

  function automatic ctl_t c_regop(input logic [2:0] op);
    ctl_t c = '0;
    c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_op = op;
    return c;
  endfunction

  function automatic ctl_t c_pcload(input logic [1:0] src, input logic en);
    ctl_t c = '0;
    c.pc_src = src; c.pc_en = en;
    return c;
  endfunction

  function automatic ctl_t c_rstmask(input ctl_t b);
    ctl_t c = b;
    c.pc_en = 0; c.mem_read = 0; c.mem_write = 0; c.ir_write = 0;
    c.reg_write = 0; c.illegal_op = 0; c.alu_op = 3'b010;
    return c;
  endfunction

  task automatic push(input logic r, input logic rdy, input ctl_t c);
    step_t s;
    s.rst = r; s.mem_ready = rdy; s.zero = m_z;
    s.opcode = m_op; s.funct = m_fn; s.exp = c;
    q.push_back(s);
  endtask

  // fs/ms: stall cycles in fetch / data memory; abort: reset hits the last MEMWR cycle
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fs, input int ms, input bit abort);
    int   ra;
    ctl_t br;
    m_op = op; m_fn = fn; m_z = z;
    repeat (fs) push(0, 0, c_fetch(0));
    push(0, 1, c_fetch(1));
    ra = r_alu(fn);
    case (op)
      6'b100011: begin
        push(0, idle_rdy, c_decode(0));
        push(0, idle_rdy, c_imm_add());
        repeat (ms) push(0, 0, c_mem(0));
        push(0, 1, c_mem(0));
        push(0, idle_rdy, c_wb(1, 0));
      end
      6'b101011: begin
        push(0, idle_rdy, c_decode(0));
        push(0, idle_rdy, c_imm_add());
        repeat (ms) push(0, 0, c_mem(1));
        if (abort) push(1, 0, c_rstmask(c_mem(1)));
        else       push(0, 1, c_mem(1));
      end
      6'b000000: begin
        if (ra < 0) begin
          push(0, idle_rdy, c_decode(1));
        end else begin
          push(0, idle_rdy, c_decode(0));
          push(0, idle_rdy, c_regop(ra[2:0]));
          push(0, idle_rdy, c_wb(0, 1));
        end
      end
      6'b000100: begin
        push(0, idle_rdy, c_decode(0));
        br = c_regop(3'b110);
        br.pc_src = 2'b01; br.pc_en = z;
        push(0, idle_rdy, br);
      end
      6'b001000: begin
        push(0, idle_rdy, c_decode(0));
        push(0, idle_rdy, c_imm_add());
        push(0, idle_rdy, c_wb(0, 0));
      end
      6'b000010: begin
        push(0, idle_rdy, c_decode(0));
        push(0, idle_rdy, c_pcload(2'b10, 1));
      end
      default: push(0, idle_rdy, c_decode(1));
    endcase
  endtask

  // Drive queued cycles back to back, inputs changed 1 time unit after the edge
  task automatic play(input string t);
    step_t s;
    tag = t;
    trace.delete();
    while (q.size() > 0) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      rst = s.rst; mem_ready = s.mem_ready; zero = s.zero;
      opcode = s.opcode; funct = s.funct; cur_exp = s.exp;
      chk_en = 1'b1;
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  function automatic int count_regw();
    int n = 0;
    foreach (trace[i]) if (trace[i].reg_write) n++;
    return n;
  endfunction

  function automatic int first_regw();
    foreach (trace[i]) if (trace[i].reg_write) return i + 1;
    return 0;
  endfunction

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (2) @(posedge clk);
    m_op = 6'b0; m_fn = 6'b0; m_z = 1'b0;
    push(1, 1, c_rstmask(c_fetch(1)));
    play("reset");

    model_instr(6'b100011, 6'b0, 0, 0, 0, 0);
    check("lw_len", q.size(), 5);
    play("lw");
    check("lw_regw_cycle", first_regw(), 5);
    check("lw_mem_to_reg", trace[4].mem_to_reg, 1);

    model_instr(6'b100011, 6'b0, 0, 0, 3, 0);
    check("lw_stall_len", q.size(), 8);
    play("lw_stall");
    check("lw_stall_regw_cycle", first_regw(), 8);
    check("lw_stall_regw_cnt", count_regw(), 1);
    check("lw_stall_memrd_hold", trace[3].mem_read & trace[4].mem_read
                                 & trace[5].mem_read & trace[6].mem_read, 1);

    idle_rdy = 1'b0;
    model_instr(6'b000000, 6'b100010, 0, 0, 0, 0);
    check("sub_len", q.size(), 4);
    play("sub");
    check("sub_alu_op", trace[2].alu_op, 6);
    check("sub_reg_dst", trace[3].reg_dst, 1);

    model_instr(6'b000000, 6'b101010, 1, 0, 0, 0);
    play("slt");
    check("slt_alu_op", trace[2].alu_op, 7);

    model_instr(6'b000000, 6'b100100, 0, 1, 0, 0);
    model_instr(6'b000000, 6'b100101, 0, 0, 0, 0);
    model_instr(6'b000000, 6'b100000, 0, 0, 0, 0);
    play("r_mix");

    idle_rdy = 1'b1;
    model_instr(6'b101011, 6'b0, 0, 0, 0, 0);
    check("sw_len", q.size(), 4);
    play("sw");
    model_instr(6'b101011, 6'b0, 0, 2, 1, 0);
    play("sw_stall");

    model_instr(6'b001000, 6'b0, 0, 0, 0, 0);
    check("addi_len", q.size(), 4);
    play("addi");

    model_instr(6'b000100, 6'b0, 1, 0, 0, 0);
    check("beq_len", q.size(), 3);
    play("beq_taken");
    check("beq_taken_pc_en", trace[2].pc_en, 1);
    check("beq_taken_pc_src", trace[2].pc_src, 1);
    model_instr(6'b000100, 6'b0, 0, 0, 0, 0);
    play("beq_not_taken");
    check("beq_nt_pc_en", trace[2].pc_en, 0);

    model_instr(6'b000010, 6'b0, 0, 0, 0, 0);
    check("j_len", q.size(), 3);
    play("jump");
    check("j_pc_src", trace[2].pc_src, 2);

    model_instr(6'b111111, 6'b0, 0, 0, 0, 0);
    model_instr(6'b000000, 6'b000111, 0, 0, 0, 0);
    model_instr(6'b001000, 6'b0, 0, 0, 0, 0);
    play("illegal");
    check("illegal_op_pulse1", trace[1].illegal_op, 1);
    check("illegal_fn_pulse2", trace[3].illegal_op, 1);
    check("illegal_no_regw", count_regw(), 1);

    model_instr(6'b101011, 6'b0, 0, 0, 2, 1);
    model_instr(6'b100011, 6'b0, 0, 2, 0, 0);
    play("rst_memwr");
    check("rst_memwr_write_off", trace[5].mem_write, 0);
    check("rst_restart_ir_hold", trace[6].ir_write | trace[7].ir_write, 0);
    check("rst_restart_ir_load", trace[8].ir_write, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
